// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard unit.
package hazard_pkg;

    // Operand source select: register file, or bypass from the E, M or W stage.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    // Common width that T_use/T_new fields are widened to before comparing.
    localparam int TMAX_W = 16;

    // True when the producer will not have its result in time for the consumer.
    function automatic logic tnew_late(input logic [TMAX_W-1:0] tnew,
                                       input logic [TMAX_W-1:0] tuse);
        return tnew > tuse;
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Busy tracker for the multi-cycle multiply/divide unit.
module md_busy_ctr #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] cnt;

    // Load on a start while idle, count down while busy; a start during busy is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end else if (start) begin
            cnt <= is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: D-stage stall, E-stage flush, operand forward selects and stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int TW       = 3,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    D_rs,
    input  logic [AW-1:0]    D_rt,
    input  logic [TW-1:0]    D_rs_tuse,
    input  logic [TW-1:0]    D_rt_tuse,
    input  logic [AW-1:0]    E_rs,
    input  logic [AW-1:0]    E_rt,
    input  logic [AW-1:0]    M_rt,
    input  logic [AW-1:0]    E_dst,
    input  logic [AW-1:0]    M_dst,
    input  logic [AW-1:0]    W_dst,
    input  logic [TW-1:0]    E_tnew,
    input  logic [TW-1:0]    M_tnew,
    input  logic [TW-1:0]    W_tnew,
    input  logic             E_we,
    input  logic             M_we,
    input  logic             W_we,
    input  logic             E_md_start,
    input  logic             E_md_div,
    input  logic             D_md_use,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_a,
    output logic [1:0]       fwd_e_b,
    output logic [1:0]       fwd_m_wd,
    output logic             stall,
    output logic             e_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // A producer feeds a source only for a real (non-zero) register it is writing.
    function automatic logic hit(input logic [AW-1:0] src,
                                 input logic [AW-1:0] dst,
                                 input logic          we);
        return (src != '0) && (src == dst) && we;
    endfunction

    // Nearest matching stage decides; a not-yet-ready nearest match falls back to RF.
    function automatic fwd_sel_e pick(input logic me, input logic mm, input logic mw,
                                      input logic e_rdy, input logic m_rdy,
                                      input logic w_rdy);
        if (me) return e_rdy ? FWD_E : FWD_RF;
        if (mm) return m_rdy ? FWD_M : FWD_RF;
        if (mw) return w_rdy ? FWD_W : FWD_RF;
        return FWD_RF;
    endfunction

    // Stall when the nearest in-flight producer is later than the consumer's need.
    function automatic logic src_stall(input logic me, input logic mm,
                                       input logic [TW-1:0] tuse,
                                       input logic [TW-1:0] etnew,
                                       input logic [TW-1:0] mtnew);
        if (me) return tnew_late(TMAX_W'(etnew), TMAX_W'(tuse));
        if (mm) return tnew_late(TMAX_W'(mtnew), TMAX_W'(tuse));
        return 1'b0;
    endfunction

    logic rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;
    logic ea_m, ea_w, eb_m, eb_w, wd_w;
    logic e_rdy, m_rdy, w_rdy;
    logic reg_stall, md_stall;

    assign rs_e = hit(D_rs, E_dst, E_we);
    assign rs_m = hit(D_rs, M_dst, M_we);
    assign rs_w = hit(D_rs, W_dst, W_we);
    assign rt_e = hit(D_rt, E_dst, E_we);
    assign rt_m = hit(D_rt, M_dst, M_we);
    assign rt_w = hit(D_rt, W_dst, W_we);
    assign ea_m = hit(E_rs, M_dst, M_we);
    assign ea_w = hit(E_rs, W_dst, W_we);
    assign eb_m = hit(E_rt, M_dst, M_we);
    assign eb_w = hit(E_rt, W_dst, W_we);
    assign wd_w = hit(M_rt, W_dst, W_we);

    assign e_rdy = (E_tnew == '0);
    assign m_rdy = (M_tnew == '0);
    assign w_rdy = (W_tnew == '0);

    assign fwd_d_rs = pick(rs_e, rs_m, rs_w, e_rdy, m_rdy, w_rdy);
    assign fwd_d_rt = pick(rt_e, rt_m, rt_w, e_rdy, m_rdy, w_rdy);
    assign fwd_e_a  = pick(1'b0, ea_m, ea_w, 1'b0, m_rdy, w_rdy);
    assign fwd_e_b  = pick(1'b0, eb_m, eb_w, 1'b0, m_rdy, w_rdy);
    assign fwd_m_wd = pick(1'b0, 1'b0, wd_w, 1'b0, 1'b0, w_rdy);

    assign reg_stall = src_stall(rs_e, rs_m, D_rs_tuse, E_tnew, M_tnew)
                     | src_stall(rt_e, rt_m, D_rt_tuse, E_tnew, M_tnew);

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_ctr (
        .clk     (clk),
        .reset   (reset),
        .start   (E_md_start),
        .is_div  (E_md_div),
        .md_busy (md_busy)
    );

    // The start cycle itself also blocks HI/LO users, before the counter is loaded.
    assign md_stall = D_md_use & (E_md_start | md_busy);
    assign stall    = reg_stall | md_stall;
    assign e_flush  = stall;

    // Count stalled cycles, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
